// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks: scheduler FSM states,
// default neuron parameters and the saturating adder used by every datapath.
package snn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StDone
  } sched_state_e;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefThreshold = 32;

  // min(a + b, 2^width - 1); operands must already fit in width bits (width <= 31)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire update for one neuron, shared by
// all virtual neurons of the scheduler.
module lif_update_unit
  import snn_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned THRESHOLD = DefThreshold
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] state_i,
  input  logic             spike_prev_i,
  output logic [WIDTH-1:0] state_next_o,
  output logic             spike_new_o
);

  localparam logic [WIDTH-1:0] Thresh = WIDTH'(THRESHOLD);

  logic [WIDTH-1:0] leak;

  // A neuron that fired last timestep restarts from its accumulated input only
  assign leak         = spike_prev_i ? '0 : (state_i >> 2);
  assign state_next_o = WIDTH'(sat_add(32'(acc_i), 32'(leak), WIDTH));
  assign spike_new_o  = (state_i >= Thresh);

endmodule

// File: rtl/neuron_step_scheduler.sv
// Time-multiplexes one LIF update datapath over N_NEURONS virtual neurons:
// accumulate weighted events while idle, sweep all neurons on step, publish spikes.
module neuron_step_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = 8,
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned THRESHOLD = DefThreshold,
  localparam int unsigned IDX_W    = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_idx,
  input  logic [WIDTH-1:0]     in_weight,
  input  logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_vec
);

  sched_state_e fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WIDTH-1:0]     acc_q  [N_NEURONS];
  logic [WIDTH-1:0]     acc_d  [N_NEURONS];
  logic [WIDTH-1:0]     vmem_q [N_NEURONS];
  logic [WIDTH-1:0]     vmem_d [N_NEURONS];
  logic [N_NEURONS-1:0] spike_prev_q, spike_prev_d;
  logic [N_NEURONS-1:0] shadow_q, shadow_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;

  logic             in_idx_ok;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] state_next;
  logic             spike_new;

  lif_update_unit #(
    .WIDTH    (WIDTH),
    .THRESHOLD(THRESHOLD)
  ) u_lif (
    .acc_i       (acc_q[idx_q]),
    .state_i     (vmem_q[idx_q]),
    .spike_prev_i(spike_prev_q[idx_q]),
    .state_next_o(state_next),
    .spike_new_o (spike_new)
  );

  assign in_idx_ok = (32'(in_idx) < N_NEURONS);
  assign acc_sum   = WIDTH'(sat_add(32'(acc_q[in_idx]), 32'(in_weight), WIDTH));

  assign in_ready  = (fsm_q == StIdle);
  assign busy      = (fsm_q == StUpdate);
  assign done      = (fsm_q == StDone);
  assign spike_vec = spike_vec_q;

  always_comb begin
    fsm_d        = fsm_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    vmem_d       = vmem_q;
    spike_prev_d = spike_prev_q;
    shadow_d     = shadow_q;
    spike_vec_d  = spike_vec_q;

    unique case (fsm_q)
      StIdle: begin
        if (in_valid && in_idx_ok) begin
          acc_d[in_idx] = acc_sum;
        end
        if (step) begin
          fsm_d = StUpdate;
          idx_d = '0;
        end
      end
      StUpdate: begin
        vmem_d[idx_q]       = state_next;
        spike_prev_d[idx_q] = spike_new;
        acc_d[idx_q]        = '0;
        shadow_d[idx_q]     = spike_new;
        if (idx_q == IDX_W'(N_NEURONS - 1)) begin
          fsm_d       = StDone;
          // Load the output with the last spike folded in so it is valid alongside done
          spike_vec_d = shadow_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        fsm_d = StIdle;
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= StIdle;
      idx_q        <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        acc_q[i]  <= '0;
        vmem_q[i] <= '0;
      end
      spike_prev_q <= '0;
      shadow_q     <= '0;
      spike_vec_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      vmem_q       <= vmem_d;
      spike_prev_q <= spike_prev_d;
      shadow_q     <= shadow_d;
      spike_vec_q  <= spike_vec_d;
    end
  end

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: an 8-neuron instance checked against a
// timestep model with a spike-vector scoreboard, plus a 6-neuron instance.
module tb_neuron_step_scheduler;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid8, step8;
  logic [2:0] in_idx8;
  logic [7:0] in_weight8;
  logic       in_ready8, busy8, done8;
  logic [7:0] spike_vec8;

  logic       in_valid6, step6;
  logic [2:0] in_idx6;
  logic [7:0] in_weight6;
  logic       in_ready6, busy6, done6;
  logic [5:0] spike_vec6;

  int vectors     = 0;
  int miscompares = 0;

  int         m_acc   [8];
  int         m_state [8];
  bit         m_sp    [8];
  logic [7:0] exp_q   [$];

  always #5 clk = ~clk;

  neuron_step_scheduler #(
    .N_NEURONS(8),
    .WIDTH    (8),
    .THRESHOLD(32)
  ) dut8 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .in_idx   (in_idx8),
    .in_weight(in_weight8),
    .step     (step8),
    .busy     (busy8),
    .done     (done8),
    .spike_vec(spike_vec8)
  );

  neuron_step_scheduler #(
    .N_NEURONS(6),
    .WIDTH    (8),
    .THRESHOLD(32)
  ) dut6 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid6),
    .in_ready (in_ready6),
    .in_idx   (in_idx6),
    .in_weight(in_weight6),
    .step     (step6),
    .busy     (busy6),
    .done     (done6),
    .spike_vec(spike_vec6)
  );

  // ---------------- reference model (8-neuron instance) ----------------
  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_acc[i]   = 0;
      m_state[i] = 0;
      m_sp[i]    = 1'b0;
    end
  endfunction

  function automatic void m_event(input int idx, input int w);
    m_acc[idx] = m_acc[idx] + w;
    if (m_acc[idx] > 255) m_acc[idx] = 255;
  endfunction

  function automatic void m_step();
    logic [7:0] v;
    int         ns;
    for (int i = 0; i < 8; i++) begin
      v[i] = (m_state[i] >= 32);
      ns   = m_acc[i] + (m_sp[i] ? 0 : (m_state[i] >> 2));
      if (ns > 255) ns = 255;
      m_state[i] = ns;
      m_sp[i]    = v[i];
      m_acc[i]   = 0;
    end
    exp_q.push_back(v);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input int idx, input int w);
    in_valid8  = 1'b1;
    in_idx8    = 3'(idx);
    in_weight8 = 8'(w);
    cyc();
    in_valid8  = 1'b0;
    m_event(idx, w);
  endtask

  task automatic run_step8(output logic got, output logic [7:0] vec);
    step8 = 1'b1;
    cyc();
    step8 = 1'b0;
    m_step();
    got = 1'b0;
    vec = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done8) begin
        got = 1'b1;
        vec = spike_vec8;
      end else begin
        cyc();
      end
    end
    if (got) cyc();
  endtask

  task automatic run_step6(output logic got, output logic [5:0] vec);
    step6 = 1'b1;
    cyc();
    step6 = 1'b0;
    got = 1'b0;
    vec = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done6) begin
        got = 1'b1;
        vec = spike_vec6;
      end else begin
        cyc();
      end
    end
    if (got) cyc();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    m_reset();
    vectors++;
    if ({in_ready8, busy8, done8} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl8: got ready/busy/done=%b need 100", {in_ready8, busy8, done8});
    end
    vectors++;
    if (spike_vec8 !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_spike8: got %h need 00", spike_vec8);
    end
    vectors++;
    if ({in_ready6, busy6, done6, spike_vec6} !== {3'b100, 6'h00}) begin
      miscompares++;
      $display("FAIL reset_dut6: got %b need 100000000", {in_ready6, busy6, done6, spike_vec6});
    end
  endtask

  task automatic test_integration();
    logic       got;
    logic [7:0] vec, exp;
    int         exp_state [3] = '{40, 10, 0};
    send8(3, 40);
    for (int s = 0; s < 3; s++) begin
      run_step8(got, vec);
      exp = exp_q.pop_front();
      vectors++;
      if (!got || vec !== exp) begin
        miscompares++;
        $display("FAIL integ_spike step%0d: got done=%b vec=%h need vec=%h", s, got, vec, exp);
      end
      vectors++;
      if (dut8.vmem_q[3] !== 8'(exp_state[s])) begin
        miscompares++;
        $display("FAIL integ_state3 step%0d: got %0d need %0d", s, dut8.vmem_q[3], exp_state[s]);
      end
    end
  endtask

  task automatic test_saturation();
    logic       got;
    logic [7:0] vec, exp;
    send8(1, 200);
    send8(1, 100);
    run_step8(got, vec);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || vec !== exp) begin
      miscompares++;
      $display("FAIL sat_spike0: got done=%b vec=%h need %h", got, vec, exp);
    end
    vectors++;
    if (dut8.vmem_q[1] !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_state1: got %0d need 255", dut8.vmem_q[1]);
    end
    run_step8(got, vec);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || vec !== exp || vec[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_spike1: got done=%b vec=%h need %h with bit1", got, vec, exp);
    end
  endtask

  task automatic test_handshake();
    int         ready_bad = 0;
    int         done_cnt  = 0;
    int         done_at   = -1;
    int         late_bad  = 0;
    logic [7:0] vec = '0;
    logic [7:0] exp;
    in_valid8  = 1'b1;
    in_idx8    = 3'd0;
    in_weight8 = 8'd50;
    step8      = 1'b1;
    cyc();
    step8 = 1'b0;
    m_event(0, 50);
    m_step();
    // s counts cycles after the step edge; done is due in the 9th (s == 8)
    for (int s = 0; s <= 12; s++) begin
      if (s <= 8 && in_ready8 !== 1'b0) ready_bad++;
      if (s >= 9 && (in_ready8 !== 1'b1 || busy8 !== 1'b0)) late_bad++;
      if (done8) begin
        done_cnt++;
        done_at   = s;
        vec       = spike_vec8;
        in_valid8 = 1'b0;
      end
      step8 = (s == 3);
      cyc();
    end
    step8     = 1'b0;
    in_valid8 = 1'b0;
    exp = exp_q.pop_front();
    vectors++;
    if (ready_bad != 0) begin
      miscompares++;
      $display("FAIL hs_ready_low: %0d of 9 cycles had in_ready high, need 0", ready_bad);
    end
    vectors++;
    if (done_cnt != 1 || done_at != 8) begin
      miscompares++;
      $display("FAIL hs_done_once: got %0d pulses at s=%0d need 1 at s=8", done_cnt, done_at);
    end
    vectors++;
    if (late_bad != 0) begin
      miscompares++;
      $display("FAIL hs_idle_after: %0d cycles not idle after done, need 0", late_bad);
    end
    vectors++;
    if (vec !== exp) begin
      miscompares++;
      $display("FAIL hs_spike: got %h need %h", vec, exp);
    end
    vectors++;
    if (dut8.vmem_q[0] !== 8'(m_state[0])) begin
      miscompares++;
      $display("FAIL hs_state0: got %0d need %0d", dut8.vmem_q[0], m_state[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic       got;
    logic [7:0] vec, exp;
    int         done_seen = 0;
    int         nz        = 0;
    send8(2, 100);
    send8(5, 60);
    step8 = 1'b1;
    cyc();
    step8 = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      cyc();
      if (done8) done_seen++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_reset();
    vectors++;
    if ({in_ready8, busy8, done8, spike_vec8} !== {3'b100, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset_out: got rdy/busy/done/vec=%b need 10000000000",
               {in_ready8, busy8, done8, spike_vec8});
    end
    for (int s = 0; s < 10; s++) begin
      cyc();
      if (done8) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_nodone: got %0d done pulses need 0", done_seen);
    end
    run_step8(got, vec);
    exp = exp_q.pop_front();
    vectors++;
    if (!got || vec !== exp || vec !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_spike: got done=%b vec=%h need 00", got, vec);
    end
    for (int i = 0; i < 8; i++) if (dut8.vmem_q[i] !== 8'h00) nz++;
    vectors++;
    if (nz != 0) begin
      miscompares++;
      $display("FAIL mid_reset_states: %0d nonzero states need 0", nz);
    end
  endtask

  task automatic test_out_of_range();
    logic       got;
    logic [5:0] vec;
    int         nz = 0;
    in_valid6  = 1'b1;
    in_idx6    = 3'd7;
    in_weight6 = 8'd255;
    vectors++;
    if (in_ready6 !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_accept: got in_ready=%b need 1", in_ready6);
    end
    cyc();
    in_valid6 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      run_step6(got, vec);
      vectors++;
      if (!got || vec !== 6'h00) begin
        miscompares++;
        $display("FAIL oor_spike step%0d: got done=%b vec=%h need 00", s, got, vec);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (dut6.vmem_q[i] !== 8'h00 || dut6.acc_q[i] !== 8'h00) nz++;
    end
    vectors++;
    if (nz != 0) begin
      miscompares++;
      $display("FAIL oor_storage: %0d neurons changed need 0", nz);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid8  = 1'b0;
    step8      = 1'b0;
    in_idx8    = '0;
    in_weight8 = '0;
    in_valid6  = 1'b0;
    step6      = 1'b0;
    in_idx6    = '0;
    in_weight6 = '0;
    m_reset();

    test_reset();
    test_integration();
    test_saturation();
    test_handshake();
    test_reset_mid();
    test_out_of_range();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left need 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
